// File: rtl/alu_pipe_md.sv
// -----------------------------------------------------------------------------
// alu_pipe_md
//   EX-stage ALU with valid/ready handshaking on both sides, a tag carried
//   alongside each operation, a single-cycle multiplier and a WIDTH-cycle
//   restoring divider for the RISC-V DIV/DIVU/REM/REMU family.
//
//   Pipeline: S1 input register -> EX (combinational, or divider FSM) ->
//   output register. Delivery is strictly in order: while a divide occupies
//   S1 nothing behind it can move.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   in_valid/ready  input handshake; in_a, in_b, in_op, in_tag payload
//   out_valid/ready output handshake; out_result, out_tag payload
//   out_carry, out_overflow, out_zero, out_negative  flags of out_result
//   busy            divider FSM is not idle
// -----------------------------------------------------------------------------
module alu_pipe_md #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_negative,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    // S1 register
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;

    // Divider state
    div_state_t       div_state;
    div_state_t       div_state_next;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_dvsr;
    logic [SHW-1:0]   div_cnt;
    logic             div_q_neg;
    logic             div_r_neg;

    // Handshake
    logic s1_is_div;
    logic s1_signed;
    logic s1_rem_op;
    logic out_free;
    logic s1_adv;
    logic accept;

    // Opcodes 11xx are the divide family; op[1] selects signed, op[0] remainder.
    assign s1_is_div = s1_op[3] & s1_op[2];
    assign s1_signed = s1_op[1];
    assign s1_rem_op = s1_op[0];

    assign out_free = !out_valid || out_ready;
    assign s1_adv   = s1_valid && out_free && (!s1_is_div || div_state == DIV_DONE);
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;
    assign busy     = (div_state != DIV_IDLE);

    // ---------------------------------------------------------------- S1 stage
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: payload flops carry no reset; s1_valid qualifies them, so their
    // power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_a   <= in_a;
            s1_b   <= in_b;
            s1_op  <= in_op;
            s1_tag <= in_tag;
        end
    end

    // ----------------------------------------------------------- divider FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            div_state <= DIV_IDLE;
        end else begin
            div_state <= div_state_next;
        end
    end

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        div_state_next = div_state;
        case (div_state)
            DIV_IDLE: if (s1_valid && s1_is_div) div_state_next = DIV_RUN;
            DIV_RUN:  if (div_cnt == '0)         div_state_next = DIV_DONE;
            DIV_DONE: if (out_free)              div_state_next = DIV_IDLE;
            default:                             div_state_next = DIV_IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits.
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    always_comb begin
        trial = {div_rem, div_quo[WIDTH-1]};
        diff  = trial - {1'b0, div_dvsr};
        if (!diff[WIDTH]) begin
            step_rem = diff[WIDTH-1:0];
            step_quo = {div_quo[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = trial[WIDTH-1:0];
            step_quo = {div_quo[WIDTH-2:0], 1'b0};
        end
    end

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // The most-negative value negates to itself, which is its correct
    // unsigned magnitude.
    assign a_mag = (s1_signed && s1_a[WIDTH-1]) ? -s1_a : s1_a;
    assign b_mag = (s1_signed && s1_b[WIDTH-1]) ? -s1_b : s1_b;

    always_ff @(posedge clk) begin
        case (div_state)
            DIV_IDLE: begin
                if (s1_valid && s1_is_div) begin
                    div_quo   <= a_mag;
                    div_dvsr  <= b_mag;
                    div_rem   <= '0;
                    div_cnt   <= SHW'(WIDTH - 1);
                    div_q_neg <= s1_signed & (s1_a[WIDTH-1] ^ s1_b[WIDTH-1]);
                    div_r_neg <= s1_signed & s1_a[WIDTH-1];
                end
            end
            DIV_RUN: begin
                div_rem <= step_rem;
                div_quo <= step_quo;
                div_cnt <= div_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    // Signed fix-up. Divide-by-zero is forced explicitly because the sign
    // correction would otherwise corrupt it. MIN / -1 needs no special case:
    // |MIN| / 1 = MIN with a positive quotient sign, remainder 0.
    logic [WIDTH-1:0] div_result;

    always_comb begin
        if (s1_b == '0) begin
            div_result = s1_rem_op ? s1_a : '1;
        end else if (s1_rem_op) begin
            div_result = div_r_neg ? -div_rem : div_rem;
        end else begin
            div_result = div_q_neg ? -div_quo : div_quo;
        end
    end

    // ------------------------------------------------------------------- EX
    logic [WIDTH:0]     add_ext;
    logic [WIDTH-1:0]   sub_res;
    logic [2*WIDTH-1:0] prod;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   ex_result;
    logic               ex_carry;
    logic               ex_overflow;

    assign add_ext = {1'b0, s1_a} + {1'b0, s1_b};
    assign sub_res = s1_a - s1_b;
    assign prod    = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
    assign shamt   = s1_b[SHW-1:0];

    always_comb begin
        ex_result   = '0;
        ex_carry    = 1'b0;
        ex_overflow = 1'b0;
        case (s1_op)
            OP_ADD: begin
                ex_result   = add_ext[WIDTH-1:0];
                ex_carry    = add_ext[WIDTH];
                ex_overflow = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                              (add_ext[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_SUB: begin
                ex_result   = sub_res;
                ex_carry    = (s1_a >= s1_b);
                ex_overflow = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                              (sub_res[WIDTH-1] != s1_a[WIDTH-1]);
            end
            OP_AND:   ex_result = s1_a & s1_b;
            OP_OR:    ex_result = s1_a | s1_b;
            OP_XOR:   ex_result = s1_a ^ s1_b;
            OP_SLL:   ex_result = s1_a << shamt;
            OP_SLT:   ex_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_SLTU:  ex_result = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
            OP_SRL:   ex_result = s1_a >> shamt;
            OP_SRA:   ex_result = $unsigned($signed(s1_a) >>> shamt);
            OP_MUL:   ex_result = prod[WIDTH-1:0];
            OP_MULHU: ex_result = prod[2*WIDTH-1:WIDTH];
            default:  ex_result = div_result;
        endcase
    end

    // ------------------------------------------------------- output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_tag      <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_negative <= 1'b0;
        end else if (s1_adv) begin
            out_valid    <= 1'b1;
            out_result   <= ex_result;
            out_tag      <= s1_tag;
            out_carry    <= ex_carry;
            out_overflow <= ex_overflow;
            out_zero     <= (ex_result == '0);
            out_negative <= ex_result[WIDTH-1];
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: doc/alu_pipe_md.md
Name: alu_pipe_md

Overview:
Parametrised successor to the team's fixed 32-bit pipelined ALU. Adds valid/ready handshaking with backpressure, an ID tag carried through, a 1-cycle multiply and a WIDTH-cycle iterative divide/remainder unit, with RISC-V flag and corner-case semantics. It sits in the EX stage of the pipelined core, between operand forwarding and the EX/MEM register.

Parameters:
WIDTH, 32, operand/result width (>=8, even)
TAG_W, 5, width of the tag passed through unchanged (e.g. rd index)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation offered
in_ready  out  1  block accepts operation this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  4  operation code
in_tag  in  TAG_W  tag
out_valid  out  1  result held in output register
out_ready  in  1  consumer takes result this cycle
out_result  out  WIDTH  result
out_tag  out  TAG_W  tag of the result
out_carry, out_overflow, out_zero, out_negative  out  1 each  flags
busy  out  1  divider FSM not IDLE

Behaviour:
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SLT, 0111 SLTU, 1000 SRL, 1001 SRA, 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned), 1100 DIVU, 1101 REMU, 1110 DIV, 1111 REM.
- Shift amount = in_b[$clog2(WIDTH)-1:0]. SLT/SLTU results are 0 or 1, zero-extended.
- Structure: S1 input register (a, b, op, tag, s1_valid), then EX, then output register (out_*).
- Accept when in_valid && in_ready. in_ready = !s1_valid || s1_adv. out_free = !out_valid || out_ready. s1_adv = out_free && (op is non-divide || div FSM in DONE).
- Latency, non-divide: an op accepted at edge k appears with out_valid=1 after edge k+1. Full throughput of 1 op/cycle when out_ready stays 1.
- Divide FSM states:
  - IDLE -> RUN when S1 holds a divide op. On entry, latch |a| and |b| (magnitudes for signed ops) and the result sign.
  - RUN: one restoring quotient bit per cycle for WIDTH cycles, then -> DONE.
  - DONE: the signed fix-up is applied. Waits for out_free, transfers to the output register, then -> IDLE.
- Divide latency: accepted at edge k, out_valid after edge k+WIDTH+2. in_ready is 0 throughout the divide.
- Divide corner cases:
  - b==0: quotient = all ones, remainder = a, for both signed and unsigned forms.
  - DIV with a = most-negative value and b = -1: quotient = a, remainder = 0.
  - Signed remainder takes the sign of the dividend.
  - These cases still take the full WIDTH+2 latency.
- Flags, computed on the final result:
  - ADD: carry = unsigned carry-out; overflow = (a_msb==b_msb) && (r_msb!=a_msb).
  - SUB: carry = 1 when a>=b unsigned (no borrow); overflow = (a_msb!=b_msb) && (r_msb!=a_msb).
  - All other ops: carry = overflow = 0.
  - zero = (result==0); negative = result msb.
- Output register holds its value and tag stable while out_valid && !out_ready.
- In-order delivery always; no op overtakes a divide.
- Reset: s1_valid=0, out_valid=0, FSM=IDLE, busy=0, out_result=0, out_tag=0, all flags=0, in_ready=1 in the cycle after reset. Reset mid-divide aborts the divide; no result is emitted.
- Simultaneous events: in the same cycle, the output register can be drained by out_ready, refilled from S1, and S1 refilled from the input.

Test Plan:
- WIDTH=32, ADD 0x7FFFFFFF+1 with out_ready=1 -> after 2 edges result 0x80000000, overflow=1, negative=1, carry=0, zero=0.
- SUB 5-5 then SUB 3-5 back-to-back -> consecutive cycles: {0, zero=1, carry=1}, then {0xFFFFFFFE, carry=0, negative=1}; tags preserved in order.
- MUL 0xFFFFFFFF*2 and MULHU of the same operands -> 0xFFFFFFFE and 0x00000001.
- DIV -7/2 then REM -7/2 -> each out_valid 34 edges after accept, results 0xFFFFFFFD and 0xFFFFFFFF; in_ready=0 while busy. DIVU 9/0 -> 0xFFFFFFFF; DIV 0x80000000/-1 -> 0x80000000.
- Hold out_ready=0 while issuing 3 ADDs -> the first 2 are accepted, in_ready drops, output stays stable; release -> all 3 are delivered in order with no loss.
- Assert rst during RUN of a DIV -> next cycle out_valid=0, busy=0, in_ready=1, flags 0; no stale result appears afterwards.
